// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory-side blocks.
package cpu_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Saturating increment used by the starvation counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v < lim) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Grant selection between fetch and load/store. D normally wins, but after
// STARVE_MAX D grants in a row with a fetch waiting, the fetch is forced through.
module arb_prio
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_reg;
  logic [STARVE_W-1:0] starve_cnt_next;
  logic                force_i;

  // Same-cycle grant decision; only meaningful while the arbiter is idle.
  always_comb begin
    force_i = i_req && (starve_cnt_reg == STARVE_LIM);
    d_gnt   = idle && d_req && !force_i;
    i_gnt   = idle && i_req && !d_gnt;
  end

  // Count D wins that bypassed a pending fetch; an I grant clears the count.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (d_gnt && i_req) begin
      starve_cnt_next = sat_inc(starve_cnt_reg, STARVE_LIM);
    end else if (i_gnt) begin
      starve_cnt_next = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction in flight: IDLE (grant) -> ISSUE (m_req until m_ready)
// -> WAIT (until m_rvalid) -> IDLE, with the response pulsed one cycle later.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          err
);

  state_t        state_reg;
  state_t        state_next;
  owner_t        owner_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] i_rdata_reg;
  logic [DW-1:0] d_rdata_reg;
  logic          i_rvalid_reg;
  logic          d_rvalid_reg;
  logic          err_reg;
  logic          arb_idle;
  logic          rsp_take;

  // Grants are suppressed while reset is held so every output reads 0.
  assign arb_idle = (state_reg == IDLE) && !rst;

  arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk  (clk),
    .rst  (rst),
    .idle (arb_idle),
    .i_req(i_req),
    .d_req(d_req),
    .i_gnt(i_gnt),
    .d_gnt(d_gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_gnt || d_gnt) state_next = ISSUE;
      ISSUE:   if (m_ready)        state_next = WAIT;
      WAIT:    if (m_rvalid)       state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    m_req    = (state_reg == ISSUE);
    busy     = (state_reg != IDLE);
    rsp_take = (state_reg == WAIT) && m_rvalid;
  end

  // Capture the granted request; held stable on m_* for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg <= OWN_I;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (d_gnt) begin
      owner_reg <= OWN_D;
      we_reg    <= d_we;
      addr_reg  <= d_addr;
      wdata_reg <= d_wdata;
    end else if (i_gnt) begin
      owner_reg <= OWN_I;
      we_reg    <= 1'b0;
      addr_reg  <= i_addr;
      wdata_reg <= '0;
    end
  end

  // Route the memory response to its owner; flag responses nobody asked for.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      i_rvalid_reg <= rsp_take && (owner_reg == OWN_I);
      d_rvalid_reg <= rsp_take && (owner_reg == OWN_D);
      if (rsp_take && (owner_reg == OWN_I)) begin
        i_rdata_reg <= m_rdata;
      end
      if (rsp_take && (owner_reg == OWN_D)) begin
        d_rdata_reg <= we_reg ? '0 : m_rdata;
      end
      if (m_rvalid && (state_reg != WAIT)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign m_we     = we_reg;
  assign m_addr   = addr_reg;
  assign m_wdata  = wdata_reg;
  assign i_rvalid = i_rvalid_reg;
  assign d_rvalid = d_rvalid_reg;
  assign i_rdata  = i_rdata_reg;
  assign d_rdata  = d_rdata_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic        busy, err;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},    {i_gnt, d_gnt}, 2'b00);
    chk({tag, "_rvalid"}, {i_rvalid, d_rvalid}, 2'b00);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_m_req_we"}, {m_req, m_we}, 2'b00);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          rdy_dly;
    int          lat;
    logic [31:0] exp_rdata;
    bit          exp_mwe;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t tbl[5];

  // One isolated transaction; other side requests during ISSUE/WAIT to prove no grant.
  task automatic do_txn(input vec_t v);
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1; i_addr = v.addr; d_wdata = v.wdata;
    end
    #1;
    chk("txn_gnt", {i_gnt, d_gnt}, v.is_d ? 2'b01 : 2'b10);
    tick();
    for (int k = 0; k <= v.rdy_dly; k++) begin
      i_req = 1; d_req = 1;
      m_ready = (k == v.rdy_dly);
      #1;
      chk("issue_m_req", m_req, 1);
      chk("issue_m_addr", m_addr, v.addr);
      chk("issue_m_we", m_we, v.exp_mwe);
      chk("issue_m_wdata", m_wdata, v.exp_mwdata);
      chk("issue_busy_nogrant", {busy, i_gnt, d_gnt}, 3'b100);
      tick();
    end
    m_ready = 0;
    for (int k = 0; k < v.lat; k++) begin
      #1;
      chk("wait_state", {m_req, busy, i_gnt, d_gnt, i_rvalid, d_rvalid}, 6'b010000);
      tick();
    end
    i_req = 0; d_req = 0;
    m_rvalid = 1; m_rdata = v.mrdata;
    tick();
    m_rvalid = 0; m_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rsp_rvalid", {i_rvalid, d_rvalid}, v.is_d ? 2'b01 : 2'b10);
    chk("rsp_rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    chk("rsp_idle", busy, 0);
    $display("txn %s we=%0d addr=%h rdata=%h", v.is_d ? "D" : "I", v.we, v.addr,
             v.is_d ? d_rdata : i_rdata);
    tick();
    chk("rsp_pulse_end", {i_rvalid, d_rvalid}, 2'b00);
    chk("rsp_hold", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
  endtask

  // Reference-model state for random traffic.
  logic [31:0] model_mem[8];
  logic [31:0] bmem[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rvalid = 0; m_rdata = 0;

    tbl[0] = '{0, 0, 32'h100, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[1] = '{1, 0, 32'h44,  32'h77,        32'h1234_5678, 1, 2, 32'h1234_5678, 0, 32'h77};
    tbl[2] = '{1, 1, 32'h20,  32'h55,        32'hCAFE_F00D, 0, 1, 32'h0,         1, 32'h55};
    tbl[3] = '{0, 0, 32'h200, 32'hFFFF_0000, 32'hA5A5_5A5A, 5, 3, 32'hA5A5_5A5A, 0, 32'h0};
    tbl[4] = '{1, 0, 32'h8,   32'h99,        32'h0BAD_CAFE, 2, 0, 32'h0BAD_CAFE, 0, 32'h99};

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    chk("reset_err", err, 0);
    rst = 0;
    tick();

    for (int t = 0; t < 5; t++) do_txn(tbl[t]);

    // Simultaneous: D store wins, I granted in the d_rvalid cycle.
    i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55;
    #1;
    chk("sim_gnt_d", {i_gnt, d_gnt}, 2'b01);
    tick();
    d_req = 0; m_ready = 1;
    #1;
    chk("sim_m_store", {m_req, m_we}, 2'b11);
    chk("sim_m_addr", m_addr, 32'h20);
    chk("sim_m_wdata", m_wdata, 32'h55);
    tick();
    m_ready = 0; m_rvalid = 1; m_rdata = 32'h999;
    tick();
    m_rvalid = 0;
    #1;
    chk("sim_d_rvalid", {i_rvalid, d_rvalid}, 2'b01);
    chk("sim_d_rdata", d_rdata, 0);
    chk("sim_gnt_i", {i_gnt, d_gnt}, 2'b10);
    $display("txn D store addr=20 then I grant in rvalid cycle");
    tick();
    i_req = 0; m_ready = 1;
    #1;
    chk("sim_i_m_addr", {m_req, m_we, m_addr}, {2'b10, 32'h300});
    tick();
    m_ready = 0; m_rvalid = 1; m_rdata = 32'h3300;
    tick();
    m_rvalid = 0;
    #1;
    chk("sim_i_rsp", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'h3300});
    $display("txn I fetch addr=300 rdata=%h", i_rdata);
    tick();

    // Starvation: both held; expect D x SM, then I, then D.
    for (int k = 0; k < SM + 2; k++) begin
      i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h40;
      #1;
      chk("starve_gnt", {i_gnt, d_gnt}, (k == SM) ? 2'b10 : 2'b01);
      $display("starve grant %0d: i_gnt=%0d d_gnt=%0d", k, i_gnt, d_gnt);
      tick();
      m_ready = 1;
      tick();
      m_ready = 0; m_rvalid = 1; m_rdata = 32'(k);
      tick();
      m_rvalid = 0;
    end
    i_req = 0; d_req = 0;
    tick();

    // Reset during WAIT drops the response; late m_rvalid sets err.
    i_req = 1; i_addr = 32'h400;
    tick();
    i_req = 0; m_ready = 1;
    tick();
    m_ready = 0;
    #1;
    chk("rw_in_wait", {m_req, busy}, 2'b01);
    rst = 1;
    tick();
    rst = 0;
    check_all_zero("rw_after_rst");
    chk("rw_err_clear", err, 0);
    m_rvalid = 1; m_rdata = 32'h1234;
    tick();
    m_rvalid = 0;
    check_all_zero("rw_late_rsp");
    chk("rw_err_set", err, 1);
    tick(); tick();
    check_all_zero("spur_idle");
    chk("spur_err_sticky", err, 1);
    $display("txn reset-mid-wait response dropped, err=%0d", err);
    do_txn(tbl[0]);
    chk("spur_err_still", err, 1);

    // Random traffic against the reference model.
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = $urandom;
      bmem[i] = model_mem[i];
    end
    begin
      bit          idle_m = 1, rv_due = 0, side_m = 0, exp_we_m = 0;
      bit          exp_i, exp_d, gi_prev = 0, gd_prev = 0, accepted = 0;
      int          starve_m = 0, resp_cnt = -1;
      logic [31:0] exp_rd = 0, exp_addr_m = 0, exp_wd_m = 0, resp_data = 0;
      for (int c = 0; c < 2000; c++) begin
        m_rvalid = 0;
        if (accepted) begin accepted = 0; resp_cnt = $urandom_range(0, 3); end
        if (resp_cnt == 0) begin m_rvalid = 1; m_rdata = resp_data; end
        if (resp_cnt >= 0) resp_cnt--;
        m_ready = 1'($urandom_range(0, 1));
        if (gi_prev) i_req = 0;
        else if (!i_req) begin
          if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = 32'($urandom_range(0, 7)) << 2; end
        end else if ($urandom_range(0, 15) == 0) i_req = 0;
        if (gd_prev) d_req = 0;
        else if (!d_req) begin
          if ($urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1));
            d_addr = 32'($urandom_range(0, 7)) << 2; d_wdata = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) d_req = 0;
        #1;
        exp_d = idle_m && d_req && !(i_req && starve_m == SM);
        exp_i = idle_m && i_req && !exp_d;
        chk("rnd_gnt", {i_gnt, d_gnt}, {exp_i, exp_d});
        chk("rnd_rvalid", {i_rvalid, d_rvalid}, rv_due ? (side_m ? 2'b01 : 2'b10) : 2'b00);
        if (rv_due) begin
          chk("rnd_rdata", side_m ? d_rdata : i_rdata, exp_rd);
          $display("rnd txn %s rdata=%h", side_m ? "D" : "I", side_m ? d_rdata : i_rdata);
        end
        chk("rnd_busy", busy, !idle_m);
        if (m_req) chk("rnd_m_fields", {m_we, m_addr, m_wdata}, {exp_we_m, exp_addr_m, exp_wd_m});
        rv_due = m_rvalid;
        if (m_rvalid) idle_m = 1;
        if (exp_d) begin
          if (i_req && starve_m < SM) starve_m++;
          side_m = 1; exp_we_m = d_we; exp_addr_m = d_addr; exp_wd_m = d_wdata;
          exp_rd = d_we ? 32'h0 : model_mem[d_addr[4:2]];
          if (d_we) model_mem[d_addr[4:2]] = d_wdata;
          idle_m = 0;
        end else if (exp_i) begin
          starve_m = 0; side_m = 0; exp_we_m = 0; exp_addr_m = i_addr; exp_wd_m = 0;
          exp_rd = model_mem[i_addr[4:2]];
          idle_m = 0;
        end
        gi_prev = exp_i; gd_prev = exp_d;
        if (m_req && m_ready) begin
          accepted = 1;
          if (m_we) begin bmem[m_addr[4:2]] = m_wdata; resp_data = $urandom; end
          else resp_data = bmem[m_addr[4:2]];
        end
        @(posedge clk); #1;
      end
      chk("rnd_err_clean", err, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing memory port between instruction fetch (I side) and load/store (D side).
- Sits between fetch/exe and the memory/cache model.
- Accepts one request per transaction and drives it onto the memory with a req/ready handshake.
- Waits a variable latency for the memory response, then returns it to the granted requester. Only one transaction is outstanding at a time.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, number of consecutive D grants while i_req is pending before I is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch accepted (pulse)
- i_rvalid  out  1  fetch data valid (pulse)
- i_rdata  out  DW  fetch data
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data accepted (pulse)
- d_rvalid  out  1  load data / store ack valid (pulse)
- d_rdata  out  DW  load data; 0 for stores
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_ready  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory response (read data or write ack)
- m_rdata  in  DW  memory read data
- busy  out  1  transaction in flight (state != IDLE)
- err  out  1  sticky; m_rvalid seen while not in WAIT

Behaviour:
- Reset: state=IDLE, starve_cnt=0, err=0. All outputs are 0, including the m_* and *_rdata outputs.
- FSM states:
  - IDLE: no transaction in flight.
  - ISSUE: m_req held high with latched addr/we/wdata until m_ready.
  - WAIT: waiting for m_rvalid.
- IDLE arbitration (Mealy, same cycle):
  - d_req && !(i_req && starve_cnt==STARVE_MAX) -> d_gnt=1, owner=D.
  - Otherwise, i_req -> i_gnt=1, owner=I.
  - On any grant: latch request fields, go to ISSUE.
  - At most one gnt per cycle.
- I-side requests: m_we=0, m_wdata=0.
- starve_cnt:
  - Increments on a D grant while i_req=1, saturating at STARVE_MAX.
  - Clears on an I grant.
  - Unchanged otherwise.
- ISSUE: m_req=1 while in ISSUE. If m_ready, go to WAIT next cycle; otherwise stay and hold all m_* stable.
- WAIT: m_req=0. On m_rvalid:
  - Register m_rdata into the owner's rdata (D store -> d_rdata=0).
  - Pulse the owner's rvalid next cycle.
  - Go to IDLE.
- Arbitration in the rvalid cycle: IDLE may grant a new request in the same cycle the previous rvalid pulses. Back-to-back throughput is one transaction per (2 + memory latency) cycles.
- Minimum latency: req@0 -> gnt@0, m_req@1. With m_ready@1 and m_rvalid@2, rvalid@3.
- rdata holds its last value until the next rvalid for that side.
- m_rvalid in IDLE or ISSUE: ignored, err<=1. err is cleared only by rst.
- rst mid-transaction: return to IDLE next edge and drop the in-flight response (no rvalid). A later m_rvalid sets err.
- Deassertion of req before gnt is legal: no grant is issued.

Decomposition:
- Shared package cpu_pkg:
  - State enum {IDLE, ISSUE, WAIT}.
  - Owner encoding (OWN_I=0, OWN_D=1).
  - Default AW/DW.
- One sub-module, arb_prio: combinational grant select plus starve_cnt register. The FSM and datapath latches stay in mem_arbiter.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_ready=1, m_rvalid 1 cycle later with m_rdata=0xDEADBEEF -> i_gnt@0, m_addr=0x100 m_we=0@1, i_rvalid=1 i_rdata=0xDEADBEEF@3, d_rvalid never asserted.
- Simultaneous requests:
  - Stimulus: i_req and d_req both at cycle 0; D is a store to addr 0x20, data 0x55.
  - Required: d_gnt first; m_we=1 m_wdata=0x55; d_rvalid with d_rdata=0.
  - Then i_gnt in the d_rvalid cycle.
- Starvation:
  - Stimulus: i_req held high, d_req held high, STARVE_MAX=4.
  - Required: exactly 4 d_gnt, then i_gnt, then starve_cnt=0 and D wins again.
- Backpressure: m_ready=0 for 5 cycles -> m_req, m_addr, m_wdata stable for all 6 ISSUE cycles; busy=1; no gnt accepted on either side.
- Reset mid-WAIT:
  - Stimulus: rst pulse during WAIT, then m_rvalid arrives.
  - Required: no i_rvalid/d_rvalid, err=1, all other outputs 0.
  - A following fetch completes normally.
- Spurious response: m_rvalid=1 in IDLE -> err=1 sticky, FSM stays IDLE, no rvalid.
